// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y counters, render strobes, line interrupt, frame counter,
// and a pix_ce-aligned pipeline feeding registered RGB/sync/DE pins.
module video_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CNT_W      = 10,
    parameter int COLOR_BITS = 4,
    parameter int PIPE_DELAY = 2,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pix_ce,
    input  logic [3*COLOR_BITS-1:0] palette_rgb_data,
    input  logic [CNT_W-1:0]        line_cmp,
    output logic [CNT_W-1:0]        h_pos,
    output logic [CNT_W-1:0]        v_pos,
    output logic                    next_pixel,
    output logic                    next_line,
    output logic                    next_frame,
    output logic                    vblank_pulse,
    output logic                    line_irq,
    output logic [15:0]             frame_count,
    output logic [COLOR_BITS-1:0]   vga_r,
    output logic [COLOR_BITS-1:0]   vga_g,
    output logic [COLOR_BITS-1:0]   vga_b,
    output logic                    vga_hsync,
    output logic                    vga_vsync,
    output logic                    vga_de
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // One extra bit so sync-end bounds equal to the total still fit.
    localparam logic [CNT_W:0] H_MAX    = (CNT_W+1)'(H_TOTAL - 1);
    localparam logic [CNT_W:0] V_MAX    = (CNT_W+1)'(V_TOTAL - 1);
    localparam logic [CNT_W:0] V_PRE    = (CNT_W+1)'(V_TOTAL - 2);
    localparam logic [CNT_W:0] V_LASTA  = (CNT_W+1)'(V_ACTIVE - 1);
    localparam logic [CNT_W:0] H_ACT    = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] V_ACT    = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] HS_START = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] HS_END   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] VS_START = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] VS_END   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [15:0]      frame_q;
    logic [CNT_W:0]   hx, vx;
    logic             h_last, v_last;
    logic             hsync_raw, vsync_raw, active_raw;

    logic [PIPE_DELAY-1:0]   hs_pipe_q, vs_pipe_q, de_pipe_q;
    logic [3*COLOR_BITS-1:0] rgb_q;
    logic                    hsync_q, vsync_q, de_q;

    assign hx     = {1'b0, h_q};
    assign vx     = {1'b0, v_q};
    assign h_last = (hx == H_MAX);
    assign v_last = (vx == V_MAX);

    always_comb begin
        h_d = h_last ? '0 : h_q + 1'b1;
        v_d = v_q;
        if (h_last) v_d = v_last ? '0 : v_q + 1'b1;
    end

    assign hsync_raw  = (hx >= HS_START) && (hx < HS_END);
    assign vsync_raw  = (vx >= VS_START) && (vx < VS_END);
    assign active_raw = (hx < H_ACT) && (vx < V_ACT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q       <= '0;
            v_q       <= '0;
            frame_q   <= '0;
            hs_pipe_q <= '0;
            vs_pipe_q <= '0;
            de_pipe_q <= '0;
            rgb_q     <= '0;
            hsync_q   <= ~HSYNC_POL;
            vsync_q   <= ~VSYNC_POL;
            de_q      <= 1'b0;
        end else if (pix_ce) begin
            h_q <= h_d;
            v_q <= v_d;
            if (h_last && v_last) frame_q <= frame_q + 16'd1;
            hs_pipe_q[0] <= hsync_raw;
            vs_pipe_q[0] <= vsync_raw;
            de_pipe_q[0] <= active_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hs_pipe_q[i] <= hs_pipe_q[i-1];
                vs_pipe_q[i] <= vs_pipe_q[i-1];
                de_pipe_q[i] <= de_pipe_q[i-1];
            end
            // Palette data arrives aligned with the tail of the pipeline.
            rgb_q   <= de_pipe_q[PIPE_DELAY-1] ? palette_rgb_data : '0;
            de_q    <= de_pipe_q[PIPE_DELAY-1];
            hsync_q <= ~(hs_pipe_q[PIPE_DELAY-1] ^ HSYNC_POL);
            vsync_q <= ~(vs_pipe_q[PIPE_DELAY-1] ^ VSYNC_POL);
        end
    end

    // Strobes are combinational so they coincide with the pix_ce that consumes them.
    assign next_pixel   = pix_ce;
    assign next_line    = pix_ce && h_last;
    assign next_frame   = pix_ce && h_last && (vx == V_PRE);
    assign vblank_pulse = pix_ce && h_last && (vx == V_LASTA);
    assign line_irq     = pix_ce && (h_q == '0) && (v_q == line_cmp);

    assign h_pos       = h_q;
    assign v_pos       = v_q;
    assign frame_count = frame_q;
    assign vga_r       = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
    assign vga_g       = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
    assign vga_b       = rgb_q[COLOR_BITS-1:0];
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_de      = de_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Random pix_ce / palette / line_cmp / reset stimulus on a small mode, checked each cycle
// against a model that derives everything from a linear count of pixel-clock edges.
module tb_video_timing_gen;
    localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
    localparam int CW = 4, CB = 4, PD = 2;
    localparam bit HPOL = 1'b1, VPOL = 1'b0;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;

    logic          clk = 0, rst_n = 0, pix_ce = 0;
    logic [3*CB-1:0] pal = '0;
    logic [CW-1:0] line_cmp = '0;
    logic [CW-1:0] h_pos, v_pos;
    logic          next_pixel, next_line, next_frame, vblank_pulse, line_irq;
    logic [15:0]   frame_count;
    logic [CB-1:0] vga_r, vga_g, vga_b;
    logic          vga_hsync, vga_vsync, vga_de;

    int vectors = 0, miscompares = 0;
    int edges = 0;
    logic [3*CB-1:0] pal_last = '0;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .CNT_W(CW), .COLOR_BITS(CB), .PIPE_DELAY(PD),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .palette_rgb_data(pal), .line_cmp(line_cmp),
        .h_pos(h_pos), .v_pos(v_pos), .next_pixel(next_pixel), .next_line(next_line),
        .next_frame(next_frame), .vblank_pulse(vblank_pulse), .line_irq(line_irq),
        .frame_count(frame_count), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h (edges=%0d)", tag, $time, obs, exp, edges);
        end
    endtask

    function automatic int px_x(int n); return n % HT; endfunction
    function automatic int px_y(int n); return (n / HT) % VT; endfunction

    task automatic check_reset_state();
        chk("rst_h", 32'(h_pos), 0);
        chk("rst_v", 32'(v_pos), 0);
        chk("rst_frames", 32'(frame_count), 0);
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
        chk("rst_de", 32'(vga_de), 0);
        chk("rst_hsync", 32'(vga_hsync), 32'(!HPOL));
        chk("rst_vsync", 32'(vga_vsync), 32'(!VPOL));
        chk("rst_strobes", 32'({next_line, next_frame, vblank_pulse, line_irq}), 0);
    endtask

    task automatic check_all();
        int x, y, p, px, py;
        bit act, hs, vs;
        x = px_x(edges);
        y = px_y(edges);
        chk("h_pos", 32'(h_pos), x);
        chk("v_pos", 32'(v_pos), y);
        chk("next_pixel", 32'(next_pixel), 32'(pix_ce));
        chk("next_line", 32'(next_line), 32'(pix_ce && x == HT-1));
        chk("next_frame", 32'(next_frame), 32'(pix_ce && x == HT-1 && y == VT-2));
        chk("vblank", 32'(vblank_pulse), 32'(pix_ce && x == HT-1 && y == VA-1));
        chk("line_irq", 32'(line_irq), 32'(pix_ce && x == 0 && y == int'(line_cmp)));
        chk("frame_count", 32'(frame_count), (edges / (HT*VT)) % 65536);
        act = 0; hs = 0; vs = 0;
        if (edges >= PD + 1) begin
            p  = edges - PD - 1;
            px = px_x(p);
            py = px_y(p);
            act = (px < HA) && (py < VA);
            hs  = (px >= HA+HFP) && (px < HA+HFP+HS);
            vs  = (py >= VA+VFP) && (py < VA+VFP+VS);
        end
        chk("vga_de", 32'(vga_de), 32'(act));
        chk("vga_rgb", 32'({vga_r, vga_g, vga_b}), act ? 32'(pal_last) : 0);
        chk("vga_hsync", 32'(vga_hsync), 32'(hs ? HPOL : !HPOL));
        chk("vga_vsync", 32'(vga_vsync), 32'(vs ? VPOL : !VPOL));
    endtask

    initial begin
        #23;
        check_reset_state();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 900 || cyc == 2100 || cyc == 2555) begin
                // Reset lands mid-cycle; no clock edge between assertion and check.
                pix_ce = 0;
                #2 rst_n = 0;
                #1 check_reset_state();
                @(posedge clk);
                edges = 0;
                pal_last = '0;
                continue;
            end
            rst_n = 1;
            if (cyc < 600)       pix_ce = 1;
            else if (cyc < 1400) pix_ce = (cyc % 2 == 0);
            else                 pix_ce = ($urandom_range(0, 3) != 0);
            pal = 12'($urandom);
            if (cyc % 150 == 0) line_cmp = 4'($urandom_range(0, 15));
            #1 check_all();
            @(posedge clk);
            if (pix_ce) begin
                edges++;
                pal_last = pal;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
